// File: rtl/reg_file.sv
// Two-read, one-write register file with a hard-wired zero register and synchronous reset.
// Define REG_FILE_BYPASS_EN for write-first forwarding of rd_data onto matching read ports.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic                  wr_en;

  // Reset wins over a pending write; index 0 is never a real destination.
  assign wr_en = reg_write && !reset && (rd_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    read_data1 = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    read_data2 = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
    // wr_en already excludes index 0 and reset, so forwarding never leaks there.
    if (wr_en && (rs1_addr == rd_addr)) read_data1 = rd_data;
    if (wr_en && (rs2_addr == rd_addr)) read_data2 = rd_data;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed and model-checked random stimulus for reg_file; works with or without
// REG_FILE_BYPASS_EN defined (expected values follow the same macro).
module tb_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic          clk;
  logic          reset;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          reg_write;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  int checks;
  int errors;
  logic [DW-1:0] model [NR];

  reg_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .reg_write (reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value from the reference array, with write-first forwarding when enabled.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (reg_write && !reset && (rd_addr == a)) return rd_data;
`endif
    return model[a];
  endfunction

  task automatic set_in(input logic rst, input logic we, input logic [AW-1:0] rd,
                        input logic [DW-1:0] d, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    @(negedge clk);
    reset     = rst;
    reg_write = we;
    rd_addr   = rd;
    rd_data   = d;
    rs1_addr  = r1;
    rs2_addr  = r2;
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    reg_write = 1'b0;
    rd_addr   = '0;
    rd_data   = '0;
    rs1_addr  = '0;
    rs2_addr  = '0;

    // Reset held: all indices read zero on both ports.
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      set_in(1'b1, 1'b0, '0, '0, AW'(i), AW'(NR - 1 - i));
      check($sformatf("reset_rd1_x%0d", i), read_data1, 32'h0);
      check($sformatf("reset_rd2_x%0d", NR - 1 - i), read_data2, 32'h0);
    end

    // Write x5, read back on both ports, others still zero.
    set_in(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("x5_rd1", read_data1, 32'hDEADBEEF);
    check("x5_rd2", read_data2, 32'hDEADBEEF);
    for (int i = 1; i < NR; i++) begin
      if (i != 5) begin
        set_in(1'b0, 1'b0, '0, '0, AW'(i), AW'(i));
        check($sformatf("others_zero_x%0d", i), read_data1, 32'h0);
      end
    end

    // Write to x0 discarded.
    set_in(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("x0_same_cycle", read_data1, 32'h0);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    check("x0_after", read_data1, 32'h0);
    check("x5_hold", read_data2, 32'hDEADBEEF);

    // Same-cycle read/write to x7.
    set_in(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    set_in(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd5, 5'd7);
`ifdef REG_FILE_BYPASS_EN
    check("x7_bypass_rd2", read_data2, 32'h22222222);
`else
    check("x7_nobypass_rd2", read_data2, 32'h11111111);
`endif
    check("x5_unaffected", read_data1, 32'hDEADBEEF);
    set_in(1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    check("x7_after_rd1", read_data1, 32'h22222222);
    check("x7_after_rd2", read_data2, 32'h22222222);

    // reg_write=0 with unknown data must not disturb storage.
    set_in(1'b0, 1'b0, 5'd5, 'x, 5'd5, 5'd7);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    check("nowrite_x5", read_data1, 32'hDEADBEEF);
    check("nowrite_x7", read_data2, 32'h22222222);

    // Reset beats a same-cycle write; no bypass while in reset.
    set_in(1'b0, 1'b1, 5'd3, 32'h12345678, 5'd0, 5'd0);
    set_in(1'b1, 1'b1, 5'd4, 32'hAAAAAAAA, 5'd3, 5'd4);
    check("rst_pre_x3", read_data1, 32'h12345678);
    check("rst_no_bypass_x4", read_data2, 32'h0);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    check("rst_x3_cleared", read_data1, 32'h0);
    check("rst_x4_dropped", read_data2, 32'h0);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    check("rst_x5_cleared", read_data1, 32'h0);
    check("rst_x7_cleared", read_data2, 32'h0);

    // First write after reset behaves normally.
    set_in(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8);
    check("post_rst_x9", read_data1, 32'hCAFEF00D);
    check("post_rst_x8", read_data2, 32'h0);

    // Random traffic against the reference array, starting from a known reset state.
    set_in(1'b1, 1'b0, '0, '0, '0, '0);
    @(posedge clk);
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int n = 0; n < 1000; n++) begin
      set_in(($urandom_range(0, 49) == 0), 1'($urandom), AW'($urandom), $urandom,
             AW'($urandom), AW'($urandom));
      check($sformatf("rand%0d_rd1", n), read_data1, exp_read(rs1_addr));
      check($sformatf("rand%0d_rd2", n), read_data2, exp_read(rs2_addr));
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < NR; i++) model[i] = '0;
      end else if (reg_write && (rd_addr != '0)) begin
        model[rd_addr] = rd_data;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
